// File: rtl/div_sequencer_if.sv
// Divider-side handshake bundle: the sequencer is the master, the divider the slave.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               div_start;
  logic               div_signed;
  logic               div_annul;
  logic [WIDTH-1:0]   div_opa;
  logic [WIDTH-1:0]   div_opb;
  logic               div_ready;
  logic [2*WIDTH-1:0] div_result;

  modport master (
    output div_start, div_signed, div_annul, div_opa, div_opb,
    input  div_ready, div_result
  );

  modport slave (
    input  div_start, div_signed, div_annul, div_opa, div_opb,
    output div_ready, div_result
  );
endinterface

// File: rtl/div_sequencer.sv
// Execute-stage DIV/DIVU sequencer: latches operands, runs the divider handshake,
// stalls while busy and holds {hi,lo}. Optional macro DIV_ZERO_FAST_EN: divide-by-zero bypass.
module div_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_req,
  input  logic             signed_req,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             result_valid,
  output logic             timeout,
  div_sequencer_if.master  dv
);
  localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT            state, stateNxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opaQ, opbQ;
  logic             signedQ;
  logic             startOp, zeroFast, cntLast, annul, tmo;

  assign startOp = (state == IDLE) && div_req && !flush;
  assign cntLast = (cnt == CNT_LAST);
`ifdef DIV_ZERO_FAST_EN
  assign zeroFast = startOp && (opb == '0);
`else
  assign zeroFast = 1'b0;
`endif

  always_comb begin
    stateNxt = state;
    annul    = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: if (startOp) stateNxt = zeroFast ? DONE : BUSY;
      BUSY: begin
        // flush beats div_ready, which beats the watchdog
        if (flush) begin
          stateNxt = IDLE;
          annul    = 1'b1;
        end else if (dv.div_ready) begin
          stateNxt = DONE;
        end else if (cntLast) begin
          stateNxt = DONE;
          annul    = 1'b1;
          tmo      = 1'b1;
        end
      end
      DONE:    if (!ext_stall || flush) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      opaQ    <= '0;
      opbQ    <= '0;
      signedQ <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= stateNxt;
      if (startOp) begin
        opaQ    <= opa;
        opbQ    <= opb;
        signedQ <= signed_req;
        cnt     <= '0;
      end else if (state == BUSY && !cntLast) begin
        cnt <= cnt + CW'(1);
      end
      if (zeroFast) begin
        hi <= opa;
        lo <= '1;
      end else if (state == BUSY && !flush) begin
        if (dv.div_ready) begin
          {hi, lo} <= dv.div_result;
        end else if (cntLast) begin
          hi <= '0;
          lo <= '0;
        end
      end
    end
  end

  assign stall         = startOp || (state == BUSY);
  assign result_valid  = (state == DONE);
  assign timeout       = tmo;
  assign dv.div_start  = (state == BUSY) && !flush;
  assign dv.div_annul  = annul;
  assign dv.div_signed = signedQ;
  assign dv.div_opa    = opaQ;
  assign dv.div_opb    = opbQ;
endmodule

// File: tb/tb_div_sequencer.sv
// Randomized transaction-level bench for div_sequencer; the bench also plays the divider.
module tb_div_sequencer;
  localparam int W    = 32;
  localparam int MAXC = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          div_req, signed_req, flush, ext_stall;
  logic [W-1:0]  opa, opb, hi, lo;
  logic          stall, result_valid, timeout;
  int            checks = 0;
  int            failures = 0;

  div_sequencer_if #(.WIDTH(W)) dvIf ();

  div_sequencer #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .div_req(div_req), .signed_req(signed_req),
    .opa(opa), .opb(opb), .flush(flush), .ext_stall(ext_stall),
    .stall(stall), .hi(hi), .lo(lo), .result_valid(result_valid),
    .timeout(timeout), .dv(dvIf.master)
  );

  always #5 clk = ~clk;

  task automatic chkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Arithmetic divider reference; divide-by-zero returns arbitrary data that must pass through.
  function automatic logic [63:0] divModel(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    logic signed [W-1:0] sq, sr;
    if (b == '0) return {$urandom, $urandom};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  // readyAt/flushAt = 0 means never; hold = extra DONE cycles with ext_stall high.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                       input int readyAt, input int flushAt, input int hold);
    logic [63:0] res, expRes;
    bit          fast, flushed;
    fast    = 1'b0;
    flushed = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    fast = (b == '0);
`endif
    res = divModel(a, b, sgn);
    div_req = 1'b1; signed_req = sgn; opa = a; opb = b;
    flush = 1'b0; ext_stall = 1'b0; dvIf.div_ready = 1'b0;
    @(negedge clk);
    chkEq("req_stall", stall, 1);
    chkEq("req_start", dvIf.div_start, 0);
    chkEq("req_valid", result_valid, 0);
    nextCyc();
    expRes = {a, 32'hFFFF_FFFF};
    if (!fast) begin
      for (int k = 1; k <= MAXC; k++) begin
        div_req = 1'($urandom); signed_req = 1'($urandom); opa = $urandom; opb = $urandom;
        flush = (k == flushAt);
        dvIf.div_ready  = (k == readyAt);
        dvIf.div_result = (k == readyAt) ? res : {$urandom, $urandom};
        @(negedge clk);
        chkEq("busy_stall", stall, 1);
        chkEq("busy_start", dvIf.div_start, !flush);
        chkEq("busy_opa", dvIf.div_opa, a);
        chkEq("busy_opb", dvIf.div_opb, b);
        chkEq("busy_signed", dvIf.div_signed, sgn);
        chkEq("busy_annul", dvIf.div_annul, flush || (k == MAXC && k != readyAt));
        chkEq("busy_timeout", timeout, !flush && k != readyAt && k == MAXC);
        chkEq("busy_valid", result_valid, 0);
        nextCyc();
        if (flush) begin flushed = 1'b1; break; end
        if (k == readyAt) begin expRes = res; break; end
        if (k == MAXC) expRes = '0;
      end
    end
    div_req = 1'b0; flush = 1'b0; dvIf.div_ready = 1'b0;
    if (flushed) begin
      @(negedge clk);
      chkEq("flush_valid", result_valid, 0);
      chkEq("flush_stall", stall, 0);
      chkEq("flush_start", dvIf.div_start, 0);
      nextCyc();
    end else begin
      for (int h = 0; h <= hold; h++) begin
        ext_stall = (h < hold);
        @(negedge clk);
        chkEq("done_valid", result_valid, 1);
        chkEq("done_hilo", {hi, lo}, expRes);
        chkEq("done_stall", stall, 0);
        chkEq("done_start", dvIf.div_start, 0);
        nextCyc();
      end
    end
    // stray div_ready in IDLE must be ignored
    ext_stall = 1'b0; dvIf.div_ready = 1'b1; dvIf.div_result = {$urandom, $urandom};
    @(negedge clk);
    chkEq("idle_valid", result_valid, 0);
    chkEq("idle_stall", stall, 0);
    chkEq("idle_hilo", {hi, lo}, flushed ? {hi, lo} : expRes);
    nextCyc();
    dvIf.div_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; div_req = 1'b0; signed_req = 1'b0; opa = '0; opb = '0;
    flush = 1'b0; ext_stall = 1'b0; dvIf.div_ready = 1'b0; dvIf.div_result = '0;
    repeat (2) @(posedge clk);
    #1;
    chkEq("rst_stall", stall, 0);
    chkEq("rst_valid", result_valid, 0);
    chkEq("rst_hilo", {hi, lo}, 0);
    chkEq("rst_ctrl", {dvIf.div_start, dvIf.div_annul, dvIf.div_signed, timeout}, 0);
    chkEq("rst_ops", {dvIf.div_opa, dvIf.div_opb}, 0);
    rst = 1'b0;
    nextCyc();

    runOp(32'd100, 32'd7, 1'b0, 34, 0, 0);
    runOp(-32'sd7, 32'd2, 1'b1, 5, 0, 0);
    runOp($urandom, 32'd9, 1'b0, 20, 5, 0);
    runOp($urandom, 32'd3, 1'b1, 10, 0, 3);
    runOp($urandom, 32'd11, 1'b0, 0, 0, 0);
    runOp($urandom, 32'd13, 1'b0, MAXC, 0, 1);
    runOp($urandom, 32'd17, 1'b1, 6, 6, 0);
    runOp(32'd5, 32'd0, 1'b0, 6, 0, 0);

    // reset in the middle of BUSY: no annul pulse, everything back to idle
    div_req = 1'b1; opa = 32'd77; opb = 32'd3; signed_req = 1'b1;
    nextCyc();
    div_req = 1'b0;
    repeat (3) nextCyc();
    rst = 1'b1;
    #1;
    chkEq("midrst_annul", dvIf.div_annul, 0);
    chkEq("midrst_stall", stall, 0);
    chkEq("midrst_start", dvIf.div_start, 0);
    chkEq("midrst_opa", dvIf.div_opa, 0);
    nextCyc();
    rst = 1'b0;
    nextCyc();

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 50)) : W'($urandom));
      runOp(ra, rb, 1'($urandom), $urandom_range(1, 44),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 42) : 0, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
